// File: rtl/stream_uart_dump.sv
// Byte-stream capture stage: buffers incoming bytes in a small FIFO and
// serialises them as UART 8N1. Bytes arriving while the FIFO is full are dropped and counted.
module stream_uart_dump #(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       uart_tx,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_q, drop_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic pop, push, drop, baud_done;

  // State register and all control flops
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by count_q alone
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    baud_done = (baud_q == BAUD_LAST);
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = START;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (baud_done) begin
          state_d = DATA;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          state_d = IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: tx is registered from the next state so the line changes on the transition edge
  always_comb begin
    pop = (state_q == IDLE) && (count_q != '0);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping and drop accounting
  always_comb begin
    push       = in_valid && ((count_q < FULL_CNT) || pop);
    drop       = in_valid && !push;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    overflow_d = overflow_q | drop;
    drop_d     = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  assign uart_tx    = tx_q;
  assign busy       = (count_q != '0) || (state_q != IDLE);
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_stream_uart_dump.sv
// Self-checking bench for stream_uart_dump: frame-level reference model plus
// an independent line decoder, table-driven frames, directed corner cases and random traffic.
module tb_stream_uart_dump;

  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       uart_tx, busy, overflow;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;

  stream_uart_dump #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .uart_tx(uart_tx), .busy(busy), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of buffered bytes and a frame timer
  logic [7:0] m_q [$];
  logic [7:0] m_sent [$];
  bit         m_active;
  int         m_t;
  logic [7:0] m_cur;
  int         m_drops;
  bit         m_ovf;

  // Independent UART receiver on the DUT line
  logic [7:0] rx_q [$];
  int         rx_start [$];
  bit         rx_busy = 0;
  int         rx_cnt = 0;
  int         rx_ferr = 0;
  int         ncyc = 0;
  logic [7:0] rx_sh = '0;

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (!resetn) begin
      rx_busy <= 0;
      rx_cnt  <= 0;
    end else if (!rx_busy) begin
      if (!uart_tx) begin
        rx_busy <= 1;
        rx_cnt  <= 1;
        rx_start.push_back(ncyc);
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if ((rx_cnt % D == D/2) && (rx_cnt / D >= 1) && (rx_cnt / D <= 8))
        rx_sh[rx_cnt/D - 1] <= uart_tx;
      if (rx_cnt == 9*D + D/2) begin
        rx_busy <= 0;
        rx_q.push_back(rx_sh);
        if (!uart_tx) rx_ferr <= rx_ferr + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_t / D;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return m_cur[idx-1];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_sent.delete();
    m_active = 0;
    m_t      = 0;
    m_cur    = '0;
    m_drops  = 0;
    m_ovf    = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    bit pop_m, acc;
    pop_m = !m_active && (m_q.size() > 0);
    acc   = v && ((m_q.size() < DEPTH) || pop_m);
    if (m_active) begin
      m_t++;
      if (m_t == 10*D) m_active = 0;
    end
    if (pop_m) begin
      m_cur    = m_q.pop_front();
      m_active = 1;
      m_t      = 0;
      m_sent.push_back(m_cur);
    end
    if (acc) m_q.push_back(d);
    else if (v) begin
      m_ovf = 1;
      if (m_drops < 255) m_drops++;
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_step(v, d);
    #1;
    chk("uart_tx", uart_tx, exp_tx());
    chk("busy", busy, (m_q.size() != 0) || m_active);
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drops);
  endtask

  task automatic do_reset();
    in_valid = 0;
    resetn   = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", uart_tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drops", drop_count, 0);
    resetn = 1;
    rx_q.delete();
    rx_start.delete();
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && busy; i++) cycle(0, 8'h00);
    chk("drain_timeout", busy, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs [5];
  logic [7:0] exp_bytes [$];

  initial begin
    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h00, 10'b1_00000000_0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0};
    vecs[3] = '{8'h3C, 10'b1_00111100_0};
    vecs[4] = '{8'h81, 10'b1_10000001_0};

    // Reset and idle
    do_reset();
    repeat (50) cycle(0, 8'h00);

    // Table-driven single frames, line checked mid-bit
    for (int n = 0; n < 5; n++) begin
      rx_q.delete();
      cycle(1, vecs[n].data);
      for (int k = 0; k < 10; k++)
        for (int j = 0; j < D; j++) begin
          cycle(0, 8'h00);
          if (j == D/2) chk($sformatf("frame%0d_bit%0d", n, k), uart_tx, vecs[n].frame[k]);
        end
      cycle(0, 8'h00);
      chk("single_busy_low", busy, 0);
      chk("single_ovf", overflow, 0);
      repeat (3) cycle(0, 8'h00);
      chk("single_rx_count", rx_q.size(), 1);
      if (rx_q.size() == 1) chk("single_rx_byte", rx_q[0], vecs[n].data);
    end

    // Burst overflow
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, 8'h10 + 8'(i));
    chk("burst_ovf", overflow, 1);
    chk("burst_drops", drop_count, 1);
    drain(6*41 + 20);
    repeat (3) cycle(0, 8'h00);
    chk("burst_rx_count", rx_q.size(), 5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("burst_rx_byte", rx_q[i], 8'h10 + i);
    for (int i = 1; i < 5 && i < rx_start.size(); i++)
      chk("burst_spacing", rx_start[i] - rx_start[i-1], 41);

    // Full FIFO plus push on the pop edge
    do_reset();
    cycle(1, 8'h55);
    for (int i = 1; i <= 4; i++) cycle(1, 8'h60 + 8'(i));
    repeat (37) cycle(0, 8'h00);
    chk("fullpop_busy", busy, 1);
    cycle(1, 8'h65);
    chk("fullpop_drops", drop_count, 0);
    drain(6*41 + 20);
    repeat (3) cycle(0, 8'h00);
    exp_bytes = '{8'h55, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    chk("fullpop_rx_count", rx_q.size(), 6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++) chk("fullpop_rx_byte", rx_q[i], exp_bytes[i]);

    // Reset during data bit 3 of 0xFF, with another byte still queued
    do_reset();
    cycle(1, 8'hFF);
    cycle(1, 8'h77);
    repeat (17) cycle(0, 8'h00);
    #2 resetn = 0;
    #1;
    chk("midrst_tx", uart_tx, 1);
    chk("midrst_busy", busy, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    rx_q.delete();
    rx_start.delete();
    cycle(1, 8'h00);
    drain(100);
    repeat (20) cycle(0, 8'h00);
    chk("midrst_rx_count", rx_q.size(), 1);
    if (rx_q.size() == 1) chk("midrst_rx_byte", rx_q[0], 0);
    chk("midrst_ferr", rx_ferr, 0);

    // Drop counter saturation
    do_reset();
    repeat (300) cycle(1, 8'hC3);
    chk("sat_drops", drop_count, 255);
    chk("sat_ovf", overflow, 1);
    repeat (50) cycle(0, 8'h00);
    chk("sat_drops_hold", drop_count, 255);
    drain(6*41 + 20);
    chk("sat_ovf_hold", overflow, 1);

    // Random traffic at several densities
    do_reset();
    foreach (exp_bytes[i]) exp_bytes[i] = '0;
    for (int p = 0; p < 3; p++) begin
      int pct;
      pct = (p == 0) ? 3 : (p == 1) ? 10 : 60;
      for (int i = 0; i < 700; i++)
        cycle(($urandom_range(0, 99) < pct), 8'($urandom));
    end
    drain(6*41 + 20);
    repeat (3) cycle(0, 8'h00);
    chk("rand_rx_count", rx_q.size(), m_sent.size());
    for (int i = 0; i < rx_q.size() && i < m_sent.size(); i++)
      chk("rand_rx_byte", rx_q[i], m_sent[i]);
    chk("rand_ferr", rx_ferr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_uart_dump.md
# stream_uart_dump

Downstream capture stage for the iCE40 BRAM-readout test designs. Accepts the byte stream a ROM-walker stage produces (one byte per cycle, no backpressure) into a small FIFO and serialises each byte as UART 8N1 for inspection on a host terminal. The FIFO is sized to absorb short bursts. Bytes that arrive while the FIFO is full are dropped and counted, so the host can tell a lossy dump from a clean one.

## Interface

- CLK_DIV, 104, clock cycles per UART bit; legal range ≥ 2 (104 gives 115200 baud at 12 MHz).
- FIFO_DEPTH, 16, FIFO entries; must be a power of two, ≥ 2.

- clk  in  1  system clock; all logic on posedge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data carries a byte this cycle.
- in_data  in  8  byte to dump.
- uart_tx  out  1  UART serial output, idle high.
- busy  out  1  high while the FIFO is non-empty or a frame is in flight.
- overflow  out  1  sticky; set on the first dropped byte.
- drop_count  out  8  number of dropped bytes, saturating at 255.

## Operation

- FIFO: FIFO_DEPTH x 8, with registered read/write pointers and an occupancy count of width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- Write rule: when in_valid is sampled high, the byte is written if count < FIFO_DEPTH, or if a pop happens in the same cycle. Otherwise the byte is dropped.
- On each dropped byte: overflow <= 1, and drop_count increments unless it is already 255.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx = 1. If count > 0, pop the head into an 8-bit shift register and go to START.
  - START: uart_tx = 0 for CLK_DIV cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLK_DIV cycles; the shift register shifts right after each bit. After bit 7, go to STOP.
  - STOP: uart_tx = 1 for CLK_DIV cycles, then go to IDLE.
- uart_tx is driven from a register; it has no combinational path from any input.
- busy = (count != 0) || (state != IDLE), registered-equivalent. A single write followed by a pop in the same edge therefore keeps busy high.
- Simultaneous push and pop: count is unchanged, and data order is preserved.

## Timing

- Reset values: uart_tx = 1, busy = 0, overflow = 0, drop_count = 0, FIFO empty, state = IDLE, bit and baud counters = 0.
- Reset asserted mid-frame: all of the above take effect asynchronously. The frame is truncated, and FIFO contents are discarded.
- Latency: a byte written at edge N into an empty FIFO with IDLE state is popped at edge N+1. uart_tx falls after edge N+1.
- Frame length: 10·CLK_DIV cycles, followed by at least 1 IDLE cycle. Back-to-back frames therefore repeat every 10·CLK_DIV+1 cycles.
- The baud counter reloads at each state/bit boundary, so there is no cumulative drift.
- overflow and drop_count update at the edge where the byte is dropped.

## Test plan

All scenarios use CLK_DIV=4 and FIFO_DEPTH=4.

- **Reset:** Hold resetn low, then release. uart_tx=1, busy=0, overflow=0, drop_count=0 for 50 idle cycles.
- **Single byte:** Push 0xA5 at edge 0. From edge 1, uart_tx shows start 0 (4 cycles), then 1,0,1,0,0,1,0,1 (4 cycles each), then stop 1 (4 cycles). busy falls after the stop bit. overflow stays 0.
- **Burst overflow:** Push 0x10..0x15 on 6 consecutive edges. 0x10 is popped at edge 1. Count reaches 4 at edge 4. 0x15 is dropped, giving overflow=1 and drop_count=1. Exactly 0x10..0x14 appear on uart_tx, in order, with 41-cycle frame spacing.
- **Full plus pop:** Fill the FIFO to 4 while a frame is ending, and push at the IDLE-pop edge. The byte is accepted, drop_count is unchanged, and all bytes are transmitted.
- **Reset mid-frame:** Assert resetn during data bit 3 of 0xFF. uart_tx=1 immediately, and the FIFO is empty. After release, push 0x00: exactly one clean frame of 0x00 is sent.
- **Saturation:** With a full FIFO, hold in_valid high for 300 cycles. drop_count=255 and stays there, and overflow=1 until the next reset.
